// File: rtl/vbs_me_pkg.sv
// Shared types for the variable-block-size motion-estimation sequencer:
// PE shift selects, FSM states and the motion-vector record.
package vbs_me_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    DOWN  = 2'd1,
    UP    = 2'd2,
    RIGHT = 2'd3
  } sel_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic signed [7:0] x;
    logic signed [7:0] y;
  } mv_t;

  localparam mv_t MV_ZERO = '{x: 8'sd0, y: 8'sd0};

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vbs_me_if.sv
// Bus between the ME sequencer, the frame-buffer BRAM ports, the PE array
// and the macroblock-level encoder control.
interface vbs_me_if
  import vbs_me_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int SAD_W  = 16
);
  logic              start;
  logic              busy;
  logic              done;
  logic              curr_rd_en;
  logic [ADDR_W-1:0] curr_addr;
  logic              ref_rd_en;
  logic [ADDR_W-1:0] ref_addr;
  logic              ref_rd_row;
  sel_t              sel;
  logic              cand_valid;
  logic [SAD_W-1:0]  sad_in;
  logic [SAD_W-1:0]  best_sad;
  logic signed [7:0] best_mvx;
  logic signed [7:0] best_mvy;

  modport master (
    input  start, sad_in,
    output busy, done, curr_rd_en, curr_addr, ref_rd_en, ref_addr, ref_rd_row,
           sel, cand_valid, best_sad, best_mvx, best_mvy
  );

  modport slave (
    output start, sad_in,
    input  busy, done, curr_rd_en, curr_addr, ref_rd_en, ref_addr, ref_rd_row,
           sel, cand_valid, best_sad, best_mvx, best_mvy
  );
endinterface

// File: rtl/vbs_me_best.sv
// Aligns each issued candidate's MV with its SAD (SAD_LAT-deep delay line)
// and keeps the strictly smallest SAD seen, so ties favour the earlier candidate.
module vbs_me_best
  import vbs_me_pkg::*;
#(
  parameter int SAD_W   = 16,
  parameter int SAD_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             cand_valid,
  input  mv_t              cand_mv,
  input  logic [SAD_W-1:0] sad_in,
  output logic [SAD_W-1:0] best_sad,
  output mv_t              best_mv
);

  logic [SAD_LAT-1:0] vld_dl;
  mv_t                mv_dl [SAD_LAT];

  // NOTE: the delay line is reset like ordinary state, not left as a RAM,
  // so a mid-run reset cannot leave stale valids that trigger late compares.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_dl <= '0;
      for (int i = 0; i < SAD_LAT; i++) mv_dl[i] <= MV_ZERO;
    end else begin
      vld_dl[0] <= cand_valid;
      mv_dl[0]  <= cand_mv;
      for (int i = 1; i < SAD_LAT; i++) begin
        vld_dl[i] <= vld_dl[i-1];
        mv_dl[i]  <= mv_dl[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_sad <= '1;
      best_mv  <= MV_ZERO;
    end else if (clear) begin
      best_sad <= '1;
      best_mv  <= MV_ZERO;
    end else if (vld_dl[SAD_LAT-1] && (sad_in < best_sad)) begin
      best_sad <= sad_in;
      best_mv  <= mv_dl[SAD_LAT-1];
    end
  end

endmodule

// File: rtl/vbs_me_ctrl.sv
// Motion-estimation sequencer: loads the current block and first reference rows,
// snake-scans the search window and reports the minimum-SAD motion vector.
module vbs_me_ctrl
  import vbs_me_pkg::*;
#(
  parameter int BLK     = 2,
  parameter int SR      = 4,
  parameter int SAD_W   = 16,
  parameter int SAD_LAT = 2,
  parameter int ADDR_W  = 8
) (
  input  logic     clk,
  input  logic     rst,
  vbs_me_if.master bus
);

  localparam int W     = 2 * SR + BLK - 1;
  localparam int N     = (2 * SR) * (2 * SR);
  localparam int CNT_W = $clog2(max3(N, BLK, SAD_LAT) + 1);

  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLK - 1);
  localparam logic [CNT_W-1:0] N_LAST   = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(SAD_LAT - 1);
  localparam logic [7:0]       Y_LAST   = 8'(2 * SR - 1);

  // Everything the controller drives, registered as one record.
  typedef struct packed {
    logic              busy;
    logic              done;
    logic              curr_rd_en;
    logic [ADDR_W-1:0] curr_addr;
    logic              ref_rd_en;
    logic [ADDR_W-1:0] ref_addr;
    logic              ref_rd_row;
    sel_t              sel;
    logic              cand_valid;
    mv_t               cand_mv;
  } out_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       cx_q, cx_d, cy_q, cy_d;
  logic             down_q, down_d;
  out_t             out_q, out_d;
  logic             clear;
  logic             load_issue;
  logic [CNT_W-1:0] load_row;
  mv_t              best_mv;

  function automatic logic [ADDR_W-1:0] addr_of(input int row, input int col);
    return ADDR_W'(row * W + col);
  endfunction

  function automatic mv_t mv_of(input logic [7:0] x, input logic [7:0] y);
    mv_t mv;
    mv.x = $signed(x - 8'(SR));
    mv.y = $signed(y - 8'(SR));
    return mv;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      down_q  <= 1'b1;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      down_q  <= down_d;
      out_q   <= out_d;
    end
  end

  // Outputs for the *next* cycle are decided here and registered above.
  // NOTE: every variable gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    down_d     = down_q;
    out_d      = '0;
    out_d.sel  = HOLD;
    clear      = 1'b0;
    load_issue = 1'b0;
    load_row   = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          clear      = 1'b1;
          state_d    = LOAD;
          cnt_d      = '0;
          out_d.busy = 1'b1;
          load_issue = 1'b1;
        end
      end

      LOAD: begin
        out_d.busy = 1'b1;
        if (cnt_q == BLK_LAST) begin
          state_d          = SCAN;
          cnt_d            = '0;
          cx_d             = '0;
          cy_d             = '0;
          down_d           = 1'b1;
          out_d.cand_valid = 1'b1;
          out_d.cand_mv    = mv_of(8'd0, 8'd0);
        end else begin
          cnt_d      = cnt_q + 1'b1;
          load_issue = 1'b1;
          load_row   = cnt_q + 1'b1;
        end
      end

      SCAN: begin
        out_d.busy = 1'b1;
        if (cnt_q == N_LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d            = cnt_q + 1'b1;
          out_d.cand_valid = 1'b1;
          out_d.ref_rd_en  = 1'b1;
          if (down_q ? (cy_q != Y_LAST) : (cy_q != 8'd0)) begin
            cy_d             = down_q ? cy_q + 8'd1 : cy_q - 8'd1;
            out_d.sel        = down_q ? DOWN : UP;
            out_d.ref_rd_row = 1'b1;
            out_d.ref_addr   = addr_of(down_q ? int'(cy_d) + BLK - 1 : int'(cy_d), int'(cx_q));
          end else begin
            // Column fetch address is taken from the pre-move x position.
            cx_d             = cx_q + 8'd1;
            down_d           = !down_q;
            out_d.sel        = RIGHT;
            out_d.ref_rd_row = 1'b0;
            out_d.ref_addr   = addr_of(int'(cy_q), int'(cx_q) + BLK - 1);
          end
          out_d.cand_mv = mv_of(cx_d, cy_d);
        end
      end

      DRAIN: begin
        out_d.busy = 1'b1;
        if (cnt_q == LAT_LAST) begin
          state_d    = DONE;
          out_d.done = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_issue) begin
      out_d.curr_rd_en = 1'b1;
      out_d.curr_addr  = ADDR_W'(load_row);
      out_d.ref_rd_en  = 1'b1;
      out_d.ref_rd_row = 1'b1;
      out_d.ref_addr   = addr_of(int'(load_row), 0);
      out_d.sel        = DOWN;
    end
  end

  vbs_me_best #(
    .SAD_W   (SAD_W),
    .SAD_LAT (SAD_LAT)
  ) u_best (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .cand_valid (out_q.cand_valid),
    .cand_mv    (out_q.cand_mv),
    .sad_in     (bus.sad_in),
    .best_sad   (bus.best_sad),
    .best_mv    (best_mv)
  );

  assign bus.busy       = out_q.busy;
  assign bus.done       = out_q.done;
  assign bus.curr_rd_en = out_q.curr_rd_en;
  assign bus.curr_addr  = out_q.curr_addr;
  assign bus.ref_rd_en  = out_q.ref_rd_en;
  assign bus.ref_addr   = out_q.ref_addr;
  assign bus.ref_rd_row = out_q.ref_rd_row;
  assign bus.sel        = out_q.sel;
  assign bus.cand_valid = out_q.cand_valid;
  assign bus.best_mvx   = best_mv.x;
  assign bus.best_mvy   = best_mv.y;

endmodule
